bus_arbiter_rr: RTL and testbench

Two-master bus arbiter that computes and registers the bus grant pair {m0_grant, m1_grant}. It sits directly upstream of the bus address decoder and the data/address muxes, and drives their master-select input. Arbitration is round-robin when both masters request at once. A hold limit stops either master from starving the other. All outputs are registered.

---
 rtl/bus_arbiter_rr.sv | 108 ++++++++++
 tb/tb_bus_arbiter_rr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin bus arbiter with a hold limit.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous, active-low reset
//   m0_req     in   master 0 request (level)
//   m1_req     in   master 1 request (level)
//   m0_grant   out  master 0 owns the bus (registered)
//   m1_grant   out  master 1 owns the bus (registered)
//   grant_sel  out  data/address mux select, 0 = M0, 1 = M1; holds last owner when idle
//   handover   out  one-cycle pulse in the first cycle of every new grant
//
// Under continuous contention each master keeps the bus for exactly MAX_HOLD
// cycles before the other master takes over.
module bus_arbiter_rr #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic m0_req,
   input  logic m1_req,
   output logic m0_grant,
   output logic m1_grant,
   output logic grant_sel,
   output logic handover
);

   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_M0   = 2'd1,
      ST_M1   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               last_owner_q, last_owner_d;   // 0 = M0, 1 = M1
   logic               grant_sel_q, grant_sel_d;
   logic               handover_q, handover_d;
   logic               hold_limit;

   // The switch fires on the last permitted cycle, so the counter never
   // reaches MAX_HOLD itself.
   assign hold_limit = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = '0;
      last_owner_d = last_owner_q;
      grant_sel_d  = grant_sel_q;
      handover_d   = 1'b0;

      case (state_q)
         ST_NONE: begin
            // On contention the master that did not own the bus last wins.
            if (m0_req && (!m1_req || last_owner_q)) state_d = ST_M0;
            else if (m1_req)                         state_d = ST_M1;
         end
         ST_M0: begin
            if (!m0_req)                   state_d = m1_req ? ST_M1 : ST_NONE;
            else if (m1_req && hold_limit) state_d = ST_M1;
         end
         ST_M1: begin
            if (!m1_req)                   state_d = m0_req ? ST_M0 : ST_NONE;
            else if (m0_req && hold_limit) state_d = ST_M0;
         end
         default: state_d = ST_NONE;
      endcase

      if (state_d != state_q) begin
         if (state_d == ST_M0) begin
            last_owner_d = 1'b0;
            grant_sel_d  = 1'b0;
            handover_d   = 1'b1;
         end else if (state_d == ST_M1) begin
            last_owner_d = 1'b1;
            grant_sel_d  = 1'b1;
            handover_d   = 1'b1;
         end
      end else if ((state_q == ST_M0 && m1_req) || (state_q == ST_M1 && m0_req)) begin
         // Only contended cycles of a continuing grant count toward the limit.
         hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_NONE;
         hold_cnt_q   <= '0;
         last_owner_q <= 1'b1;
         grant_sel_q  <= 1'b0;
         handover_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_owner_q <= last_owner_d;
         grant_sel_q  <= grant_sel_d;
         handover_q   <= handover_d;
      end
   end

   assign m0_grant  = (state_q == ST_M0);
   assign m1_grant  = (state_q == ST_M1);
   assign grant_sel = grant_sel_q;
   assign handover  = handover_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic m0_req = 1'b0;
   logic m1_req = 1'b0;

   logic a_g0, a_g1, a_sel, a_ho;   // MAX_HOLD = 8
   logic b_g0, b_g1, b_sel, b_ho;   // MAX_HOLD = 1

   int checks = 0;
   int errors = 0;

   // Reference model, one entry per DUT instance.
   int unsigned mh[2] = '{8, 1};
   int   m_owner[2];   // -1 = nobody, 0 = M0, 1 = M1
   int   m_run[2];     // contended cycles since the run started
   int   m_last[2];
   logic m_sel[2];
   logic m_ho[2];

   always #5 clk = ~clk;

   bus_arbiter_rr #(.MAX_HOLD(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .m0_req(m0_req), .m1_req(m1_req),
      .m0_grant(a_g0), .m1_grant(a_g1), .grant_sel(a_sel), .handover(a_ho)
   );

   bus_arbiter_rr #(.MAX_HOLD(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .m0_req(m0_req), .m1_req(m1_req),
      .m0_grant(b_g0), .m1_grant(b_g1), .grant_sel(b_sel), .handover(b_ho)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic checkv(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1;
         m_run[k]   = 0;
         m_last[k]  = 1;
         m_sel[k]   = 1'b0;
         m_ho[k]    = 1'b0;
      end
   endtask

   // Ownership decided from the request pair and how long the owner has
   // already held the bus against a waiting competitor.
   task automatic model_step(input logic r0, input logic r1);
      int req[2];
      int nxt, o, x;
      req[0] = int'(r0);
      req[1] = int'(r1);
      for (int k = 0; k < 2; k++) begin
         nxt = m_owner[k];
         if (m_owner[k] < 0) begin
            if (req[0] == 1 && req[1] == 1) nxt = 1 - m_last[k];
            else if (req[0] == 1)           nxt = 0;
            else if (req[1] == 1)           nxt = 1;
         end else begin
            o = m_owner[k];
            x = 1 - o;
            if (req[o] == 0)                                         nxt = (req[x] == 1) ? x : -1;
            else if (req[x] == 1 && m_run[k] + 1 >= int'(mh[k]))     nxt = x;
         end
         m_ho[k] = (nxt >= 0) && (nxt != m_owner[k]);
         if (nxt != m_owner[k])                 m_run[k] = 0;
         else if (nxt >= 0 && req[1-nxt] == 1)  m_run[k] = m_run[k] + 1;
         else                                   m_run[k] = 0;
         if (nxt >= 0) begin
            m_last[k] = nxt;
            m_sel[k]  = (nxt == 1);
         end
         m_owner[k] = nxt;
      end
   endtask

   task automatic check_all();
      check("a_m0_grant",  a_g0,  m_owner[0] == 0);
      check("a_m1_grant",  a_g1,  m_owner[0] == 1);
      check("a_grant_sel", a_sel, m_sel[0]);
      check("a_handover",  a_ho,  m_ho[0]);
      check("a_exclusive", a_g0 & a_g1, 1'b0);
      check("b_m0_grant",  b_g0,  m_owner[1] == 0);
      check("b_m1_grant",  b_g1,  m_owner[1] == 1);
      check("b_grant_sel", b_sel, m_sel[1]);
      check("b_handover",  b_ho,  m_ho[1]);
      check("b_exclusive", b_g0 & b_g1, 1'b0);
   endtask

   task automatic cycle(input logic r0, input logic r1);
      m0_req = r0;
      m1_req = r1;
      @(posedge clk);
      model_step(r0, r1);
      #1;
      check_all();
   endtask

   // Pulses reset between edges; called 1 time unit after a posedge.
   task automatic pulse_reset();
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #2 reset_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      model_reset();
      #2 check_all();
      #10 reset_n = 1'b1;

      // Idle after reset
      repeat (3) cycle(1'b0, 1'b0);

      // Single master, then release
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0);
         check("t2_grant", a_g0, 1'b1);
         check("t2_ho", a_ho, i == 0);
      end
      cycle(1'b0, 1'b0);
      check("t2_release", a_g0, 1'b0);

      // Contention from reset: M0 first, 8/8/... alternation
      pulse_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1);
         if (i < 8)       check("t3_m0_first", a_g0, 1'b1);
         else if (i < 16) check("t3_m1",       a_g1, 1'b1);
         else             check("t3_m0_again", a_g0, 1'b1);
         check("t3_ho", a_ho, (i == 0) || (i == 8) || (i == 16));
      end

      // Direct M1 -> M0 handover without idle gap
      cycle(1'b0, 1'b1);
      check("t4_m1", a_g1, 1'b1);
      cycle(1'b1, 1'b0);
      check("t4_m0", a_g0, 1'b1);
      check("t4_not_m1", a_g1, 1'b0);
      check("t4_ho", a_ho, 1'b1);

      // Competitor drop restarts the hold count
      repeat (5) cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1);
         if (!a_g0) break;
         n++;
      end
      checkv("t5_hold_after_restart", n, 7);
      check("t5_switched", a_g1, 1'b1);

      // Asynchronous reset while M1 holds the bus
      cycle(1'b0, 1'b1);
      check("t6_m1_before", a_g1, 1'b1);
      pulse_reset();
      check("t6_g0_in_reset", a_g0, 1'b0);
      check("t6_g1_in_reset", a_g1, 1'b0);
      cycle(1'b1, 1'b1);
      check("t6_m0_after", a_g0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
